// File: rtl/cpu_fetch.sv
// cpu_fetch -- instruction-fetch unit with a DEPTH-entry prefetch queue.
//
// Issues sequential word reads on the CPU memory bus whenever a queue slot
// can be reserved, and presents the oldest fetched word to decode. A redirect
// flushes the queue and restarts fetch at the new PC. A read already on the
// bus cannot be aborted, so it is marked killed and its data is dropped.
//
// Optional feature macro: CPU_FETCH_BYPASS_EN
//   defined   - an unkilled bus return with the queue empty is forwarded to
//               the consumer in the same cycle (and skips the queue if taken)
//   undefined - consumer outputs come only from queue storage
//
// Ports:
//   i_clock, i_reset_n         clock, asynchronous active-low reset
//   o_request/o_rw/o_address   bus read request (o_rw always 0)
//   i_ready/i_data             bus completion and read data
//   o_valid/o_instruction/o_pc head of queue (zeros when not valid)
//   i_take                     consumer pops the head
//   i_redirect/i_redirect_pc   flush and restart fetch at a new PC
//   o_count                    queue occupancy
module cpu_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    output logic                     o_request,
    output logic                     o_rw,
    output logic [31:0]              o_address,
    input  logic                     i_ready,
    input  logic [31:0]              i_data,
    output logic                     o_valid,
    output logic [31:0]              o_instruction,
    output logic [31:0]              o_pc,
    input  logic                     i_take,
    input  logic                     i_redirect,
    input  logic [31:0]              i_redirect_pc,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state, state_next;
    logic            kill;
    logic [31:0]     fetch_pc;
    logic [31:0]     addr;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     q_pc  [DEPTH];
    logic [31:0]     q_ins [DEPTH];

    logic empty, done, good, bypass, consume, pop, push, issue;

    assign empty = (count == '0);
    assign done  = (state == S_WAIT) && i_ready;
    // A completing fetch whose data is still wanted.
    assign good  = done && !kill && !i_redirect;
`ifdef CPU_FETCH_BYPASS_EN
    assign bypass = good && empty;
`else
    assign bypass = 1'b0;
`endif
    assign consume = bypass && i_take;
    // Redirect wins over a pop; popping an empty queue does nothing.
    assign pop   = i_take && !empty && !i_redirect;
    assign push  = good && !consume;
    // Only issue when a slot is guaranteed, counting this cycle's pop, so
    // the queue can never overflow when the data returns.
    assign issue = (state == S_IDLE) && !i_redirect && ((count < CW'(DEPTH)) || pop);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (issue)   state_next = S_WAIT;
            S_WAIT: if (i_ready) state_next = S_IDLE;
            default:             state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) state <= S_IDLE;
        else            state <= state_next;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            kill     <= 1'b0;
            fetch_pc <= RESET_PC;
            addr     <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) addr <= fetch_pc;
            if (i_redirect) begin
                fetch_pc <= {i_redirect_pc[31:2], 2'b00};
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                // In-flight read keeps running on the bus; drop it on return.
                kill     <= (state == S_WAIT) && !i_ready;
            end else begin
                if (done) begin
                    if (kill) kill     <= 1'b0;
                    else      fetch_pc <= addr + 32'd4;
                end
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Queue storage needs no reset; occupancy gates every read.
    always_ff @(posedge i_clock) begin
        if (push) begin
            q_pc[wr_ptr]  <= addr;
            q_ins[wr_ptr] <= i_data;
        end
    end

    always_comb begin
        o_valid       = 1'b0;
        o_pc          = '0;
        o_instruction = '0;
        if (!empty) begin
            o_valid       = 1'b1;
            o_pc          = q_pc[rd_ptr];
            o_instruction = q_ins[rd_ptr];
        end else if (bypass) begin
            o_valid       = 1'b1;
            o_pc          = addr;
            o_instruction = i_data;
        end
    end

    assign o_request = (state == S_WAIT);
    assign o_rw      = 1'b0;
    assign o_address = addr;
    assign o_count   = count;
endmodule

// File: tb/tb_cpu_fetch.sv
module tb_cpu_fetch;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef CPU_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          i_clock = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          o_request, o_rw;
    logic [31:0]   o_address;
    logic          i_ready = 1'b0;
    logic [31:0]   i_data = '0;
    logic          o_valid;
    logic [31:0]   o_instruction, o_pc;
    logic          i_take = 1'b0;
    logic          i_redirect = 1'b0;
    logic [31:0]   i_redirect_pc = '0;
    logic [CW-1:0] o_count;

    always #5 i_clock = ~i_clock;

    cpu_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n),
        .o_request(o_request), .o_rw(o_rw), .o_address(o_address),
        .i_ready(i_ready), .i_data(i_data),
        .o_valid(o_valid), .o_instruction(o_instruction), .o_pc(o_pc),
        .i_take(i_take), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_count(o_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: queue of fetched words, outstanding-read flag, kill flag.
    logic [31:0] qpc[$];
    logic [31:0] qins[$];
    bit          m_out, m_kill;
    logic [31:0] m_fetch, m_addr;
    int          wcnt, lat, fixed_lat;
    bit          rand_lat;
    bit          byp_now, e_valid;
    logic [31:0] e_pc, e_ins;

    function automatic logic [31:0] datafn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // Drive one cycle's inputs at the current negedge and form expectations.
    task automatic cyc(input bit take, input bit redir, input logic [31:0] rpc);
        i_take = take; i_redirect = redir; i_redirect_pc = rpc;
        if (o_request && wcnt >= lat) begin
            i_ready = 1'b1; i_data = datafn(o_address);
        end else begin
            i_ready = 1'b0; i_data = $urandom;
            if (o_request) wcnt++;
        end
        #1;
        byp_now = BYP && m_out && i_ready && !m_kill && !redir && qpc.size() == 0;
        e_valid = qpc.size() > 0 || byp_now;
        e_pc    = qpc.size() > 0 ? qpc[0]  : (byp_now ? m_addr : 32'h0);
        e_ins   = qpc.size() > 0 ? qins[0] : (byp_now ? datafn(m_addr) : 32'h0);
    endtask

    // Apply the clock edge to the model, then move to the next negedge.
    task automatic advance();
        int sz;
        bit popq, cons, iss;
        sz   = qpc.size();
        popq = i_take && sz > 0 && !i_redirect;
        cons = byp_now && i_take;
        iss  = !m_out && !i_redirect && (sz - int'(popq) < DEPTH);
        if (i_redirect) begin
            qpc.delete(); qins.delete();
            m_fetch = i_redirect_pc & ~32'd3;
            if (m_out) begin
                if (i_ready) begin m_out = 0; m_kill = 0; end
                else m_kill = 1;
            end
        end else begin
            if (popq) begin void'(qpc.pop_front()); void'(qins.pop_front()); end
            if (m_out && i_ready) begin
                m_out = 0;
                if (m_kill) m_kill = 0;
                else begin
                    if (!cons) begin qpc.push_back(m_addr); qins.push_back(datafn(m_addr)); end
                    m_fetch = m_addr + 32'd4;
                end
            end
        end
        if (iss) begin
            m_out = 1; m_addr = m_fetch; wcnt = 0;
            lat = rand_lat ? int'($urandom_range(0, 4)) : fixed_lat;
        end
        @(negedge i_clock);
    endtask

    task automatic do_reset();
        #2;
        i_reset_n = 1'b0; i_ready = 1'b0; i_take = 1'b0; i_redirect = 1'b0;
        #1;
        total++; if (o_request !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", o_request); end
        total++; if (o_address !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", o_address); end
        total++; if (o_valid !== 1'b0 || o_pc !== 32'h0 || o_instruction !== 32'h0) begin
            bad++; $display("FAIL rst_head got v=%b pc=%h ins=%h want 0/0/0", o_valid, o_pc, o_instruction); end
        total++; if (o_count !== '0) begin bad++; $display("FAIL rst_count got=%0d want=0", o_count); end
        qpc.delete(); qins.delete();
        m_out = 0; m_kill = 0; m_fetch = 32'h0; m_addr = 32'h0; wcnt = 0; lat = 0;
        @(negedge i_clock);
        @(negedge i_clock);
        i_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_fill();
        logic [31:0] seen[$];
        bit prev = 0;
        rand_lat = 0; fixed_lat = 0;
        for (int c = 0; c < 14; c++) begin
            cyc(0, 0, 0);
            if (o_request && !prev) seen.push_back(o_address);
            prev = o_request;
            total++; if (o_request !== m_out) begin bad++; $display("FAIL fill_req c=%0d got=%b want=%b", c, o_request, m_out); end
            advance();
        end
        total++; if (seen.size() != 4) begin bad++; $display("FAIL fill_nreq got=%0d want=4", seen.size()); end
        for (int k = 0; k < seen.size() && k < 4; k++) begin
            total++; if (seen[k] !== 32'(k * 4)) begin bad++; $display("FAIL fill_addr k=%0d got=%h want=%h", k, seen[k], k * 4); end
        end
        total++; if (o_count !== CW'(4)) begin bad++; $display("FAIL fill_count got=%0d want=4", o_count); end
        total++; if (o_pc !== 32'h0 || o_request !== 1'b0) begin bad++; $display("FAIL fill_head got pc=%h req=%b want 0/0", o_pc, o_request); end
    endtask

    task automatic test_stream();
        logic [31:0] nxt = 32'h0;
        for (int c = 0; c < 40; c++) begin
            cyc(1, 0, 0);
            if (o_valid) begin
                total++; if (o_pc !== nxt || o_instruction !== datafn(nxt)) begin
                    bad++; $display("FAIL stream_pc got=%h/%h want=%h/%h", o_pc, o_instruction, nxt, datafn(nxt)); end
                nxt += 4;
            end
            total++; if (o_count > CW'(4) || o_count !== CW'(qpc.size())) begin
                bad++; $display("FAIL stream_count got=%0d want=%0d", o_count, qpc.size()); end
            advance();
        end
        total++; if (nxt < 32'h40) begin bad++; $display("FAIL stream_progress got=%h want>=40", nxt); end
    endtask

    task automatic test_redirect_wait();
        int n = 0;
        bit got_first = 0, prev = 0, got_req = 0;
        do_reset();
        fixed_lat = 3;
        while (!(m_out && m_addr == 32'h10) && n < 200) begin cyc(1, 0, 0); advance(); n++; end
        total++; if (n >= 200) begin bad++; $display("FAIL rw_reach got=timeout want=req 0x10"); end
        cyc(0, 1, 32'h100);
        prev = o_request;
        advance();
        for (int c = 0; c < 40; c++) begin
            cyc(1, 0, 0);
            if (o_request && !prev && !got_req) begin
                got_req = 1;
                total++; if (o_address !== 32'h100) begin bad++; $display("FAIL rw_req got=%h want=100", o_address); end
            end
            prev = o_request;
            if (o_valid) begin
                total++; if (o_pc === 32'h10) begin bad++; $display("FAIL rw_killed got=%h want!=10", o_pc); end
                if (!got_first) begin
                    got_first = 1;
                    total++; if (o_pc !== 32'h100) begin bad++; $display("FAIL rw_first got=%h want=100", o_pc); end
                end
            end
            advance();
        end
        total++; if (!got_first || !got_req) begin bad++; $display("FAIL rw_seen got=%b%b want=11", got_first, got_req); end
    endtask

    task automatic test_redirect_ready();
        int n = 0;
        bit found = 0;
        fixed_lat = 1;
        while (!(m_out && wcnt >= lat && qpc.size() > 0) && n < 100) begin cyc(0, 0, 0); advance(); n++; end
        total++; if (n >= 100) begin bad++; $display("FAIL rr_reach got=timeout want=ready cycle"); end
        cyc(1, 1, 32'h340);
        advance();
        total++; if (o_count !== '0 || o_valid !== 1'b0) begin bad++; $display("FAIL rr_flush got cnt=%0d v=%b want 0/0", o_count, o_valid); end
        for (int c = 0; c < 20 && !found; c++) begin
            cyc(0, 0, 0);
            if (o_valid) begin
                found = 1;
                total++; if (o_pc !== 32'h340) begin bad++; $display("FAIL rr_first got=%h want=340", o_pc); end
            end
            advance();
        end
        total++; if (!found) begin bad++; $display("FAIL rr_seen got=none want=valid"); end
    endtask

    task automatic test_align_wrap();
        logic [31:0] seen[$];
        bit prev;
        fixed_lat = 0;
        cyc(0, 1, 32'h203); prev = o_request; advance();
        for (int c = 0; c < 12 && seen.size() < 1; c++) begin
            cyc(0, 0, 0);
            if (o_request && !prev) seen.push_back(o_address);
            prev = o_request; advance();
        end
        total++; if (seen.size() < 1 || seen[0] !== 32'h200) begin bad++; $display("FAIL align got=%h want=200", seen.size() ? seen[0] : 32'hx); end
        seen.delete();
        cyc(0, 1, 32'hFFFF_FFFC); prev = o_request; advance();
        for (int c = 0; c < 20 && seen.size() < 2; c++) begin
            cyc(0, 0, 0);
            if (o_request && !prev) seen.push_back(o_address);
            prev = o_request; advance();
        end
        total++; if (seen.size() < 2 || seen[0] !== 32'hFFFF_FFFC || seen[1] !== 32'h0) begin
            bad++; $display("FAIL wrap got n=%0d want FFFFFFFC then 0", seen.size()); end
    endtask

    task automatic test_hold_reset();
        int n = 0;
        fixed_lat = 5;
        cyc(0, 1, 32'h500); advance();
        while (!(m_out && m_addr == 32'h500) && n < 50) begin cyc(0, 0, 0); advance(); n++; end
        total++; if (n >= 50) begin bad++; $display("FAIL hold_reach got=timeout want=req 500"); end
        for (int c = 0; c < 5; c++) begin
            cyc(0, 0, 0);
            total++; if (o_request !== 1'b1 || o_address !== 32'h500 || i_ready !== 1'b0) begin
                bad++; $display("FAIL hold_stable c=%0d got req=%b addr=%h want 1/500", c, o_request, o_address); end
            advance();
        end
        cyc(0, 0, 0);
        total++; if (o_valid !== BYP || (BYP && o_pc !== 32'h500)) begin
            bad++; $display("FAIL hold_bypass got v=%b pc=%h want v=%b", o_valid, o_pc, BYP); end
        advance();
        n = 0;
        while (!(m_out && wcnt >= 2) && n < 20) begin cyc(0, 0, 0); advance(); n++; end
        total++; if (n >= 20) begin bad++; $display("FAIL hold_second got=timeout want=req"); end
        do_reset();
    endtask

    task automatic test_random();
        rand_lat = 1;
        for (int c = 0; c < 1500; c++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rpc);
            total++; if (o_request !== m_out || o_address !== m_addr || o_rw !== 1'b0) begin
                bad++; $display("FAIL rnd_bus c=%0d got req=%b addr=%h want %b/%h", c, o_request, o_address, m_out, m_addr); end
            total++; if (o_valid !== e_valid || o_pc !== e_pc || o_instruction !== e_ins) begin
                bad++; $display("FAIL rnd_head c=%0d got %b/%h/%h want %b/%h/%h", c, o_valid, o_pc, o_instruction, e_valid, e_pc, e_ins); end
            total++; if (o_count !== CW'(qpc.size())) begin
                bad++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, o_count, qpc.size()); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_redirect_wait();
        test_redirect_ready();
        test_align_wrap();
        test_hold_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
